// File: rtl/rega_scheduler.sv
// Round-robin irrigation scheduler: one shared pump, N_ZONES valves.
// Define RAIN_LOCKOUT_EN to add the rain port and rain lockout.
module rega_scheduler #(
  parameter int N_ZONES     = 4,
  parameter int WATER_TICKS = 8,
  parameter int PAUSE_TICKS = 2,
  parameter int CNT_W       = 4,
  localparam int ZW         = $clog2(N_ZONES)
) (
  input  logic               clk,
  input  logic               clear_n,
  input  logic               tick,
  input  logic [N_ZONES-1:0] req,
`ifdef RAIN_LOCKOUT_EN
  input  logic               rain,
`endif
  output logic [N_ZONES-1:0] valve,
  output logic               pump,
  output logic [ZW-1:0]      zone_idx,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPEN,
    S_WATER,
    S_CLOSE,
    S_PAUSE
  } state_t;

  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WATER_TICKS - 1);
  localparam logic [CNT_W-1:0] P_LAST =
    CNT_W'((PAUSE_TICKS > 0) ? PAUSE_TICKS - 1 : 0);

  state_t             state, nstate;
  logic [CNT_W-1:0]   cnt, ncnt;
  logic [ZW-1:0]      last, nlast;
  logic [ZW-1:0]      nzone;
  logic [ZW-1:0]      pick;
  logic               any;
  logic               rain_hit;
  logic [N_ZONES-1:0] nvalve;
  logic               npump;
  int                 j;

`ifdef RAIN_LOCKOUT_EN
  assign rain_hit = rain;
`else
  assign rain_hit = 1'b0;
`endif

  // Search from last+1 upward; reverse loop so the nearest hit wins.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    j    = 0;
    for (int i = N_ZONES; i >= 1; i--) begin
      j = (int'(last) + i) % N_ZONES;
      if (req[j]) begin
        pick = ZW'(j);
        any  = 1'b1;
      end
    end
  end

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    nzone  = zone_idx;
    nlast  = last;
    unique case (state)
      S_IDLE: begin
        if (any && !rain_hit) begin
          nstate = S_OPEN;
          nzone  = pick;
          nlast  = pick;
        end
      end
      S_OPEN: begin
        nstate = rain_hit ? S_CLOSE : S_WATER;
        ncnt   = '0;
      end
      S_WATER: begin
        if (rain_hit || !req[zone_idx] ||
            (tick && cnt == W_LAST)) begin
          nstate = S_CLOSE;
        end else if (tick) begin
          ncnt = cnt + 1'b1;
        end
      end
      S_CLOSE: begin
        nstate = S_PAUSE;
        ncnt   = '0;
      end
      S_PAUSE: begin
        if (PAUSE_TICKS == 0) begin
          nstate = S_IDLE;
        end else if (tick) begin
          if (cnt == P_LAST) begin
            nstate = S_IDLE;
            ncnt   = '0;
          end else begin
            ncnt = cnt + 1'b1;
          end
        end
      end
      default: begin
        nstate = S_IDLE;
        ncnt   = '0;
      end
    endcase
  end

  // Valve and pump are decoded from the next state so they are registered.
  always_comb begin
    nvalve = '0;
    npump  = 1'b0;
    if (nstate == S_OPEN || nstate == S_WATER ||
        nstate == S_CLOSE) begin
      nvalve = N_ZONES'(1) << nzone;
    end
    if (nstate == S_WATER) begin
      npump = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      last     <= ZW'(N_ZONES - 1);
      zone_idx <= '0;
      valve    <= '0;
      pump     <= 1'b0;
    end else begin
      state    <= nstate;
      cnt      <= ncnt;
      last     <= nlast;
      zone_idx <= nzone;
      valve    <= nvalve;
      pump     <= npump;
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_CLOSE);

endmodule

// File: doc/rega_scheduler.md
# rega_scheduler

Round-robin irrigation scheduler that shares the single pump between up to N_ZONES watering zones. Each zone raises a level request while its soil sensor reads dry. The block grants one zone at a time and sequences that zone's valve and the shared pump through open, water, close and pause phases. Watering time is measured in ticks of an external timebase. It sits between the sensor/flip-flop conditioning logic and the valve/pump drivers.

## Interface
- N_ZONES, 4, number of zones/requesters (2..8)
- WATER_TICKS, 8, maximum watering duration in ticks per grant (>=1)
- PAUSE_TICKS, 2, dead time in ticks after each grant before the next arbitration (>=0)
- CNT_W, 4, tick counter width; must hold max(WATER_TICKS, PAUSE_TICKS)
- clk  input  1  system clock, all state on rising edge
- clear_n  input  1  asynchronous active-low reset
- tick  input  1  one-cycle timebase pulse; timers advance only on cycles with tick=1
- req  input  N_ZONES  level request per zone (1 = soil dry, wants water)
- rain  input  1  rain sensor; present only with RAIN_LOCKOUT_EN
- valve  output  N_ZONES  one-hot valve drive, registered
- pump  output  1  shared pump drive, registered
- zone_idx  output  clog2(N_ZONES)  currently/last granted zone, registered
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse on each entry to CLOSE

## Operation
- States: IDLE, OPEN, WATER, CLOSE, PAUSE.
- IDLE: valve=0, pump=0. If any req bit is set, the block picks the first set bit searching from last+1 upward, modulo N_ZONES. It loads zone_idx, updates last and goes to OPEN. With no request it stays in IDLE.
- OPEN, 1 cycle: valve[zone_idx]=1, pump=0, so the valve opens before the pump starts. Next state is WATER, with cnt cleared.
- WATER: valve[zone_idx]=1, pump=1. On each tick cnt increments.
  - Go to CLOSE when tick=1 and cnt==WATER_TICKS-1 (timeout).
  - Go to CLOSE when req[zone_idx]=0 (soil wet, early stop). This needs no tick.
- CLOSE, 1 cycle: pump=0, valve[zone_idx]=1, so the pump stops before the valve shuts. done=1. Next state is PAUSE, with cnt cleared.
- PAUSE: all outputs off. On each tick cnt increments. Go to IDLE when tick=1 and cnt==PAUSE_TICKS-1. If PAUSE_TICKS=0, go to IDLE after exactly one PAUSE cycle.
- Round-robin pointer:
  - last resets to N_ZONES-1, so zone 0 has first priority.
  - A zone that still requests after its grant waits behind every other requesting zone.
- Requests are sampled only in IDLE, and in WATER for the granted zone only. Changes on other req bits during a grant are ignored.
- At most one valve bit is set at any time. pump=1 only in WATER.

## Timing
- Reset (clear_n=0, asynchronous): state=IDLE, valve=0, pump=0, zone_idx=0, busy=0, done=0, cnt=0, last=N_ZONES-1.
- Reset asserted mid-WATER: pump and valve drop immediately, with no clock edge needed.
- Request latency:
  - req seen in IDLE at edge t: valve high after t+1 (OPEN).
  - pump high after t+2 (WATER).
- Maximum pump-on time: WATER_TICKS ticks; the tick on the WATER entry cycle counts.
- A tick arriving in IDLE, OPEN or CLOSE is ignored; it is not carried over.
- Early stop: req[zone_idx] low at edge t in WATER gives pump=0 after t+1, valve=0 after t+2.
- Timeout and early stop in the same cycle: a single CLOSE, and one done pulse.
- A grant occupies 3 + (watering cycles) + (pause cycles) cycles; the next arbitration happens in the IDLE cycle after PAUSE.

## Configuration
- RAIN_LOCKOUT_EN defined:
  - rain port exists.
  - In IDLE, rain=1 blocks all grants.
  - In OPEN or WATER, rain=1 forces the next state to CLOSE (done pulses), then PAUSE runs normally.
  - The pointer advances as for a normal grant.
- RAIN_LOCKOUT_EN undefined: no rain port, and scheduling depends on req and tick only.

## Test plan
- Reset then single request: req=4'b0100, tick every 4 cycles, defaults.
  - Expect OPEN: valve=4'b0100 with pump=0.
  - Then pump=1 for exactly 8 ticks.
  - Then CLOSE: done=1, pump=0, valve still 4'b0100.
  - Then 2-tick pause, then IDLE.
- Round-robin: req=4'b1011 held constant; expect grant order zone 0, 1, 3, 0, with zone_idx matching and busy low for exactly one cycle between grants.
- Early stop: zone 2 watering, req[2] drops after 3 ticks; expect pump=0 next cycle, valve=0 the cycle after, one done pulse, total 3 ticks watered.
- Async reset mid-WATER: pull clear_n low between clock edges; expect valve=0, pump=0, busy=0 immediately; after release with req=4'b0001, zone 0 is granted first.
- PAUSE_TICKS=0, WATER_TICKS=1, tick tied high: expect WATER of 1 cycle, PAUSE of 1 cycle, and a 5-cycle grant period with continuous req.
- RAIN_LOCKOUT_EN: rain=1 with req=4'b0001 gives no grant. Then rain=0 gives a grant. Then rain=1 during WATER gives CLOSE next cycle with done=1.
